fir_serial_mac_hpf: RTL and testbench

Time-multiplexed (single-MAC) high-pass FIR engine that consumes coefficients from the coefficient LUT stage sitting beside it. It accepts one RF sample per handshake and stores it in a circular delay line. It then walks the coefficient LUT address by address, accumulates Taps products, and emits one rounded, saturated filtered sample downstream. It sits between the sample acquisition front-end and the compression stages.

---
 rtl/fir_serial_mac_hpf.sv | 169 ++++++++++++++++
 tb/tb_fir_serial_mac_hpf.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/fir_serial_mac_hpf.sv
// fir_serial_mac_hpf
// Single-MAC, time-multiplexed high-pass FIR. One sample is accepted per
// handshake into a circular delay line. The block then walks the external
// coefficient LUT (addresses 0..Taps-1) and accumulates Taps products. The
// result is rounded half-up, saturated, and handed downstream.
//
// Ports:
//   clk_i, rst_ni              clock, synchronous active-low reset
//   in_valid_i/in_ready_o      input handshake, in_data_i signed sample
//   coeff_ren_o/coeff_addr_o   LUT read request
//   coeff_data_i               registered LUT data (one cycle after address)
//   out_valid_o/out_ready_i    output handshake, out_data_o signed result
module fir_serial_mac_hpf #(
    parameter int DataWidth  = 16,
    parameter int CoeffWidth = 16,
    parameter int Taps       = 19,
    parameter int OutShift   = 15,
    localparam int AccWidth  = DataWidth + CoeffWidth + $clog2(Taps),
    localparam int AddrWidth = $clog2(Taps)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DataWidth-1:0]  in_data_i,
    output logic                  coeff_ren_o,
    output logic [AddrWidth-1:0]  coeff_addr_o,
    input  logic [CoeffWidth-1:0] coeff_data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DataWidth-1:0]  out_data_o
);

    localparam int ProdWidth = DataWidth + CoeffWidth;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StMac  = 2'd1;
    localparam logic [1:0] StLast = 2'd2;
    localparam logic [1:0] StOut  = 2'd3;

    localparam logic [AddrWidth-1:0] LastK   = AddrWidth'(Taps - 1);
    localparam logic [AddrWidth:0]   TapsExt = (AddrWidth + 1)'(Taps);

    localparam logic signed [AccWidth-1:0] RoundC = AccWidth'(1) << (OutShift - 1);
    localparam logic signed [AccWidth-1:0] SatMax = (AccWidth'(1) << (DataWidth - 1)) - AccWidth'(1);
    localparam logic signed [AccWidth-1:0] SatMin = -(AccWidth'(1) << (DataWidth - 1));

    logic [1:0]                  state_q, state_d;
    logic [DataWidth-1:0]        dline_q [Taps];
    logic [AddrWidth-1:0]        wptr_q, wptr_d;
    logic [AddrWidth-1:0]        newest_q, newest_d;
    logic [AddrWidth-1:0]        k_q, k_d;
    logic [DataWidth-1:0]        samp_q;
    logic signed [AccWidth-1:0]  acc_q, acc_d;
    logic                        out_valid_q, out_valid_d;
    logic [DataWidth-1:0]        out_data_q, out_data_d;
    logic                        dl_we;

    logic [AddrWidth:0]          rd_ext;
    logic [AddrWidth-1:0]        rd_idx;
    logic signed [ProdWidth-1:0] prod;
    logic signed [AccWidth-1:0]  acc_sum;
    logic signed [AccWidth-1:0]  acc_rnd;
    logic signed [AccWidth-1:0]  res;
    logic [DataWidth-1:0]        res_sat;

    // Delay-line read index (newest - k) mod Taps, done one bit wider so the
    // wrap past index 0 never underflows.
    always_comb begin
        if (newest_q >= k_q) begin
            rd_ext = {1'b0, newest_q} - {1'b0, k_q};
        end else begin
            rd_ext = {1'b0, newest_q} + TapsExt - {1'b0, k_q};
        end
        rd_idx = rd_ext[AddrWidth-1:0];
    end

    // samp_q lags k_q by one cycle, matching the LUT read latency.
    assign prod    = $signed(samp_q) * $signed(coeff_data_i);
    assign acc_sum = acc_q + {{(AccWidth - ProdWidth){prod[ProdWidth-1]}}, prod};
    assign acc_rnd = acc_sum + RoundC;
    assign res     = acc_rnd >>> OutShift;

    always_comb begin
        if (res > SatMax) begin
            res_sat = SatMax[DataWidth-1:0];
        end else if (res < SatMin) begin
            res_sat = SatMin[DataWidth-1:0];
        end else begin
            res_sat = res[DataWidth-1:0];
        end
    end

    always_comb begin
        state_d     = state_q;
        wptr_d      = wptr_q;
        newest_d    = newest_q;
        k_d         = k_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        dl_we       = 1'b0;
        case (state_q)
            StIdle: begin
                if (in_valid_i) begin
                    dl_we    = 1'b1;
                    newest_d = wptr_q;
                    wptr_d   = (wptr_q == LastK) ? '0 : wptr_q + 1'b1;
                    acc_d    = '0;
                    k_d      = '0;
                    state_d  = StMac;
                end
            end
            StMac: begin
                // First coefficient arrives one cycle after address 0.
                if (k_q != '0) acc_d = acc_sum;
                if (k_q == LastK) begin
                    state_d = StLast;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            StLast: begin
                acc_d       = acc_sum;
                out_data_d  = res_sat;
                out_valid_d = 1'b1;
                state_d     = StOut;
            end
            default: begin
                if (out_ready_i) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            wptr_q      <= '0;
            newest_q    <= '0;
            k_q         <= '0;
            samp_q      <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            for (int i = 0; i < Taps; i++) dline_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            wptr_q      <= wptr_d;
            newest_q    <= newest_d;
            k_q         <= k_d;
            samp_q      <= dline_q[rd_idx];
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            if (dl_we) dline_q[wptr_q] <= in_data_i;
        end
    end

    // Ready is suppressed while reset is held, even though the state is IDLE.
    assign in_ready_o   = (state_q == StIdle) && rst_ni;
    assign coeff_ren_o  = (state_q == StMac);
    assign coeff_addr_o = k_q;
    assign out_valid_o  = out_valid_q;
    assign out_data_o   = out_data_q;

endmodule

// File: tb/tb_fir_serial_mac_hpf.sv
module tb_fir_serial_mac_hpf;

    localparam int Taps = 19;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        coeff_ren;
    logic [4:0]  coeff_addr;
    logic [15:0] coeff_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;

    int lut [Taps];
    int hist[$];
    int exp_q[$];
    int n_cmp = 0;
    int n_err = 0;
    int last_out = 0;

    always #5 clk = ~clk;

    fir_serial_mac_hpf dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .coeff_ren_o (coeff_ren),
        .coeff_addr_o(coeff_addr),
        .coeff_data_i(coeff_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data)
    );

    // Registered coefficient LUT beside the filter.
    always @(posedge clk) begin
        if (coeff_ren) coeff_data <= 16'(lut[coeff_addr]);
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int golden();
        longint acc = 0;
        longint r;
        for (int k = 0; k < Taps; k++) begin
            int idx = hist.size() - 1 - k;
            if (idx >= 0) acc += longint'(lut[k]) * longint'(hist[idx]);
        end
        r = (acc + 64'sd16384) >>> 15;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return int'(r);
    endfunction

    // Scoreboard: pop and compare on every output handshake.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            last_out = int'($signed(out_data));
            if (exp_q.size() == 0) chk("sb_extra", exp_q.size(), 1);
            else chk("sb_out", last_out, exp_q.pop_front());
        end
    end

    // Drive one sample; optionally check LUT protocol and latency.
    task automatic send(input int v, input bit timed);
        int t = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 16'(v);
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) chk("in_ready_to", int'(in_ready), 1);
        hist.push_back(v);
        exp_q.push_back(golden());
        @(posedge clk);
        #1 in_valid = 1'b0;
        if (timed) begin
            for (int j = 1; j <= 21; j++) begin
                @(negedge clk);
                chk($sformatf("lat_ren_%0d", j), int'(coeff_ren), (j <= 19) ? 1 : 0);
                if (j <= 19) chk($sformatf("lat_addr_%0d", j), int'(coeff_addr), j - 1);
                chk($sformatf("lat_ovld_%0d", j), int'(out_valid), (j == 21) ? 1 : 0);
                chk($sformatf("lat_irdy_%0d", j), int'(in_ready), 0);
            end
        end
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk("drain", exp_q.size(), 0);
    endtask

    initial begin
        lut = '{729, -762, 300, -500, 400, -600, 800, -1200, 2748, 32767,
                2748, -1200, 800, -600, 400, -500, 300, -762, 729};
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_ren", int'(coeff_ren), 0);
        chk("rst_addr", int'(coeff_addr), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", int'(in_ready), 1);

        // Impulse response
        send(16384, 1'b0);
        for (int i = 0; i < 20; i++) send(0, 1'b0);
        drain();
        chk("imp_tail", last_out, 0);

        // Latency / LUT protocol
        send(1000, 1'b1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("lat_idle", int'(in_ready), 1);
        drain();

        // Backpressure
        begin
            int t = 0;
            int held;
            out_ready = 1'b0;
            send(-12345, 1'b0);
            while (!out_valid && t < 50) begin
                @(negedge clk);
                t++;
            end
            chk("bp_valid_seen", int'(out_valid), 1);
            held = exp_q.size() ? exp_q[0] : 0;
            for (int j = 0; j < 5; j++) begin
                chk("bp_valid", int'(out_valid), 1);
                chk("bp_data", int'($signed(out_data)), held);
                chk("bp_irdy", int'(in_ready), 0);
                chk("bp_ren", int'(coeff_ren), 0);
                @(negedge clk);
            end
            @(posedge clk);
            #1 out_ready = 1'b1;
            @(negedge clk);
            @(negedge clk);
            chk("bp_done_valid", int'(out_valid), 0);
            chk("bp_done_irdy", int'(in_ready), 1);
            drain();
        end

        // Saturation
        for (int i = 0; i < 20; i++) send(32767, 1'b0);
        drain();
        chk("sat_pos", last_out, 32767);
        for (int i = 0; i < 20; i++) send(-32768, 1'b0);
        drain();
        chk("sat_neg", last_out, -32768);

        // Reset mid-MAC (k = 7)
        send(1111, 1'b0);
        send(-2222, 1'b0);
        send(3333, 1'b0);
        drain();
        send(4444, 1'b0);
        repeat (7) @(posedge clk);
        #1 rst_n = 1'b0;
        hist.delete();
        exp_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("mrst_ren", int'(coeff_ren), 0);
        chk("mrst_addr", int'(coeff_addr), 0);
        chk("mrst_out_valid", int'(out_valid), 0);
        chk("mrst_out_data", int'(out_data), 0);
        chk("mrst_irdy", int'(in_ready), 1);
        send(16384, 1'b0);
        for (int i = 0; i < 20; i++) send(0, 1'b0);
        drain();

        // Pointer wrap
        for (int n = 0; n < 40; n++) send(n + 1, 1'b0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got %0d expected %0d", 1, 0);
        $fatal(1, "timeout");
    end

endmodule
